// File: rtl/relay_decode_multi.sv
// relay_decode_multi
//
// Recovers encoded bits from a raw relay sample stream by counting ones over
// a window of WINDOW samples and comparing against THRESH. Each decoded bit
// is reported on bit_valid/bit_value and regenerated on data_out, either as
// a fixed-length pulse or as a level, depending on mode.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   mode       00 long pulse, 01 short pulse, 10 level, 11 output disabled
//   data_in    raw relay sample, synchronous to clk
//   data_out   regenerated bit stream
//   bit_valid  one-cycle strobe after each completed window
//   bit_value  last decoded bit, held until the next window completes
//   armed      receiver is accumulating windows
//   overrun    sticky flag: a 1-bit trigger was dropped during holdoff
//
// Receiver states:
//   state     | meaning
//   ST_IDLE   | disarmed, waiting for the first data_in=1
//   ST_ARMED  | accumulating samples into windows

module relay_decode_multi #(
   parameter int WINDOW       = 32,
   parameter int THRESH       = 16,
   parameter int PULSE_LONG   = 32,
   parameter int PULSE_SHORT  = 16,
   parameter int HOLDOFF      = 32,
   parameter int IDLE_WINDOWS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic       data_in,
   output logic       data_out,
   output logic       bit_valid,
   output logic       bit_value,
   output logic       armed,
   output logic       overrun
);

   localparam int CNT_W     = $clog2(WINDOW + 1);
   localparam int PULSE_MAX = (PULSE_LONG > PULSE_SHORT) ? PULSE_LONG : PULSE_SHORT;
   localparam int PULSE_W   = $clog2(PULSE_MAX + 1);
   localparam int HOLD_W    = $clog2(HOLDOFF + 1);
   localparam int IDLE_W    = $clog2(IDLE_WINDOWS + 1);

   localparam logic [CNT_W-1:0]   WINDOW_C  = CNT_W'(WINDOW);
   localparam logic [CNT_W-1:0]   THRESH_C  = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [IDLE_W-1:0]  IDLE_C    = IDLE_W'(IDLE_WINDOWS);
   localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);
   localparam logic [PULSE_W-1:0] LONG_M1   = PULSE_W'(PULSE_LONG - 1);
   localparam logic [PULSE_W-1:0] SHORT_M1  = PULSE_W'(PULSE_SHORT - 1);
   localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1);
   localparam logic [HOLD_W-1:0]  HOLD_M1   = HOLD_W'(HOLDOFF - 1);
   localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);

   localparam logic [1:0] MODE_LONG  = 2'b00;
   localparam logic [1:0] MODE_SHORT = 2'b01;
   localparam logic [1:0] MODE_LEVEL = 2'b10;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_ARMED = 1'b1;

   logic               state_q,     state_d;
   logic [CNT_W-1:0]   sample_q,    sample_d;
   logic [CNT_W-1:0]   ones_q,      ones_d;
   logic [IDLE_W-1:0]  zero_q,      zero_d;
   logic               bit_valid_q, bit_valid_d;
   logic               bit_value_q, bit_value_d;
   logic [PULSE_W-1:0] pulse_q,     pulse_d;
   logic [HOLD_W-1:0]  hold_q,      hold_d;
   logic               data_out_q,  data_out_d;
   logic               overrun_q,   overrun_d;

   logic [CNT_W-1:0]   sample_inc;
   logic [CNT_W-1:0]   ones_inc;
   logic [IDLE_W-1:0]  zero_inc;
   logic [PULSE_W-1:0] pulse_dec;
   logic [HOLD_W-1:0]  hold_dec;
   logic               win_done;
   logic               win_one;
   logic               hit;

   // The current sample is folded in before the window decision, so the
   // closing edge sees the full WINDOW-sample total.
   assign sample_inc = sample_q + CNT_ONE;
   assign ones_inc   = ones_q + {{(CNT_W-1){1'b0}}, data_in};
   assign win_done   = (sample_inc == WINDOW_C);
   assign win_one    = (ones_inc > THRESH_C);
   assign zero_inc   = (zero_q == IDLE_C) ? zero_q : zero_q + IDLE_ONE;

   assign pulse_dec  = (pulse_q != '0) ? pulse_q - PULSE_ONE : pulse_q;
   assign hold_dec   = (hold_q != '0) ? hold_q - HOLD_ONE : hold_q;
   assign hit        = bit_valid_q & bit_value_q;

   // window accumulation and idle disarm
   always_comb begin
      state_d     = state_q;
      sample_d    = sample_q;
      ones_d      = ones_q;
      zero_d      = zero_q;
      bit_valid_d = 1'b0;
      bit_value_d = bit_value_q;

      case (state_q)
         ST_IDLE: begin
            if (data_in) begin
               state_d  = ST_ARMED;
               sample_d = CNT_ONE;
               ones_d   = CNT_ONE;
            end
         end
         ST_ARMED: begin
            sample_d = sample_inc;
            ones_d   = ones_inc;
            if (win_done) begin
               sample_d    = '0;
               ones_d      = '0;
               bit_valid_d = 1'b1;
               bit_value_d = win_one;
               if (win_one) begin
                  zero_d = '0;
               end else if (zero_inc == IDLE_C) begin
                  // disarm overrides the decoded value on the same edge
                  state_d     = ST_IDLE;
                  bit_value_d = 1'b0;
                  zero_d      = '0;
               end else begin
                  zero_d = zero_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // output regeneration
   always_comb begin
      pulse_d    = pulse_q;
      hold_d     = hold_q;
      data_out_d = 1'b0;
      overrun_d  = overrun_q;

      case (mode)
         MODE_LONG, MODE_SHORT: begin
            hold_d = hold_dec;
            if (hit && (hold_q == '0)) begin
               data_out_d = 1'b1;
               pulse_d    = (mode == MODE_LONG) ? LONG_M1 : SHORT_M1;
               hold_d     = HOLD_M1;
            end else begin
               if (hit) begin
                  overrun_d = 1'b1;
               end
               data_out_d = (pulse_q != '0);
               pulse_d    = pulse_dec;
            end
         end
         MODE_LEVEL: begin
            data_out_d = bit_value_q;
            pulse_d    = '0;
            hold_d     = '0;
         end
         default: begin
            // output disabled: holdoff keeps running so a 1-bit arriving
            // inside it is still reported as an overrun
            data_out_d = 1'b0;
            pulse_d    = '0;
            hold_d     = hold_dec;
            if (hit && (hold_q != '0)) begin
               overrun_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         sample_q    <= '0;
         ones_q      <= '0;
         zero_q      <= '0;
         bit_valid_q <= 1'b0;
         bit_value_q <= 1'b0;
         pulse_q     <= '0;
         hold_q      <= '0;
         data_out_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sample_q    <= sample_d;
         ones_q      <= ones_d;
         zero_q      <= zero_d;
         bit_valid_q <= bit_valid_d;
         bit_value_q <= bit_value_d;
         pulse_q     <= pulse_d;
         hold_q      <= hold_d;
         data_out_q  <= data_out_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data_out  = data_out_q;
   assign bit_valid = bit_valid_q;
   assign bit_value = bit_value_q;
   assign armed     = (state_q == ST_ARMED);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_relay_decode_multi.sv
module tb_relay_decode_multi;

   localparam int WINDOW       = 32;
   localparam int THRESH       = 16;
   localparam int PULSE_LONG   = 32;
   localparam int PULSE_SHORT  = 16;
   localparam int HOLD_A       = 32;
   localparam int HOLD_B       = 48;
   localparam int IDLE_WINDOWS = 8;

   logic       clk;
   logic       reset;
   logic [1:0] mode;
   logic       data_in;

   logic dout_a, bv_a, bval_a, arm_a, ovr_a;
   logic dout_b, bv_b, bval_b, arm_b, ovr_b;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   relay_decode_multi #(
      .WINDOW(WINDOW), .THRESH(THRESH), .PULSE_LONG(PULSE_LONG),
      .PULSE_SHORT(PULSE_SHORT), .HOLDOFF(HOLD_A), .IDLE_WINDOWS(IDLE_WINDOWS)
   ) u_dut_a (
      .clk(clk), .reset(reset), .mode(mode), .data_in(data_in),
      .data_out(dout_a), .bit_valid(bv_a), .bit_value(bval_a),
      .armed(arm_a), .overrun(ovr_a)
   );

   relay_decode_multi #(
      .WINDOW(WINDOW), .THRESH(THRESH), .PULSE_LONG(PULSE_LONG),
      .PULSE_SHORT(PULSE_SHORT), .HOLDOFF(HOLD_B), .IDLE_WINDOWS(IDLE_WINDOWS)
   ) u_dut_b (
      .clk(clk), .reset(reset), .mode(mode), .data_in(data_in),
      .data_out(dout_b), .bit_valid(bv_b), .bit_value(bval_b),
      .armed(arm_b), .overrun(ovr_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Decoding keeps the samples of the open window in a queue and counts
   // ones when it holds WINDOW entries. Pulse timing is tracked as absolute
   // edge numbers: last high edge of the pulse and earliest edge at which a
   // new trigger is accepted.
   int m_n;
   bit m_armed;
   bit m_win[$];
   int m_zr;
   bit m_bv;
   bit m_bval;

   typedef struct {
      bit dout;
      bit ovr;
      int pulse_last;
      int ok_edge;
   } out_t;

   out_t oa, ob;

   function automatic out_t out_clear();
      out_t o;
      o.dout = 1'b0;
      o.ovr = 1'b0;
      o.pulse_last = -1;
      o.ok_edge = 0;
      return o;
   endfunction

   function automatic out_t out_next(input out_t o, input int hold, input logic [1:0] md,
                                     input bit hit, input bit old_val, input int n);
      out_t r;
      int len;
      r = o;
      len = (md == 2'b00) ? PULSE_LONG : PULSE_SHORT;
      case (md)
         2'b00, 2'b01: begin
            if (hit && n >= o.ok_edge) begin
               r.dout = 1'b1;
               r.pulse_last = n + len - 1;
               r.ok_edge = n + hold;
            end else begin
               if (hit) r.ovr = 1'b1;
               r.dout = (n <= o.pulse_last);
            end
         end
         2'b10: begin
            r.dout = old_val;
            r.pulse_last = -1;
            r.ok_edge = 0;
         end
         default: begin
            r.dout = 1'b0;
            r.pulse_last = -1;
            if (hit && n < o.ok_edge) r.ovr = 1'b1;
         end
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_n = 0;
      m_armed = 1'b0;
      m_win.delete();
      m_zr = 0;
      m_bv = 1'b0;
      m_bval = 1'b0;
      oa = out_clear();
      ob = out_clear();
   endtask

   task automatic model_step(input logic [1:0] md, input bit din);
      bit hit;
      bit old_val;
      int ones;
      hit = m_bv && m_bval;
      old_val = m_bval;
      m_n++;
      oa = out_next(oa, HOLD_A, md, hit, old_val, m_n);
      ob = out_next(ob, HOLD_B, md, hit, old_val, m_n);
      m_bv = 1'b0;
      if (!m_armed) begin
         if (din) begin
            m_armed = 1'b1;
            m_win.push_back(1'b1);
         end
      end else begin
         m_win.push_back(din);
         if (m_win.size() == WINDOW) begin
            ones = 0;
            foreach (m_win[i]) ones += int'(m_win[i]);
            m_win.delete();
            m_bv = 1'b1;
            m_bval = (ones > THRESH);
            if (m_bval) begin
               m_zr = 0;
            end else begin
               m_zr++;
               if (m_zr >= IDLE_WINDOWS) begin
                  m_armed = 1'b0;
                  m_bval = 1'b0;
                  m_zr = 0;
               end
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, " data_out_a"},  dout_a, oa.dout);
      check({tag, " bit_valid_a"}, bv_a,   m_bv);
      check({tag, " bit_value_a"}, bval_a, m_bval);
      check({tag, " armed_a"},     arm_a,  m_armed);
      check({tag, " overrun_a"},   ovr_a,  oa.ovr);
      check({tag, " data_out_b"},  dout_b, ob.dout);
      check({tag, " bit_valid_b"}, bv_b,   m_bv);
      check({tag, " bit_value_b"}, bval_b, m_bval);
      check({tag, " armed_b"},     arm_b,  m_armed);
      check({tag, " overrun_b"},   ovr_b,  ob.ovr);
   endtask

   // Model-checked segment: random stimulus, or alternating all-1/all-0
   // windows in level mode when alt is set.
   task automatic run_seg(input int cycles, input bit alt, input string tag);
      bit in_rst;
      int p;
      int d;
      @(negedge clk);
      reset = 1'b0;
      data_in = 1'b0;
      mode = alt ? 2'b10 : 2'($urandom_range(3));
      model_reset();
      in_rst = 1'b1;
      p = 50;
      d = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         compare_all(tag);
         if (in_rst) begin
            reset = 1'b1;
            in_rst = 1'b0;
         end
         if (!alt && $urandom_range(999) < 3) begin
            reset = 1'b0;
            in_rst = 1'b1;
            data_in = 1'b0;
            model_reset();
            continue;
         end
         if (alt) begin
            data_in = ((d / WINDOW) % 2) == 0;
         end else begin
            if ((c % WINDOW) == 0) begin
               case ($urandom_range(5))
                  0: p = 0;
                  1: p = 10;
                  2: p = 50;
                  3: p = 55;
                  4: p = 90;
                  default: p = 100;
               endcase
            end
            if ($urandom_range(99) < 2) mode = 2'($urandom_range(3));
            data_in = ($urandom_range(99) < p);
         end
         model_step(mode, data_in);
         d++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      data_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [1:0] md;
      int         ones;
      bit         exp_bit;
      int         exp_len;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bv_seen, cnt, first, bv_obs, na, nb, nbv, cyc;
      bit flag_arm, flag_bv, flag_dout, drop;

      vecs.push_back('{2'b00, 20, 1'b1, 32});
      vecs.push_back('{2'b01, 16, 1'b0, 0});
      vecs.push_back('{2'b01, 17, 1'b1, 16});
      vecs.push_back('{2'b00, 16, 1'b0, 0});
      vecs.push_back('{2'b00, 32, 1'b1, 32});
      vecs.push_back('{2'b01, 31, 1'b1, 16});
      vecs.push_back('{2'b10, 20, 1'b1, 32});
      vecs.push_back('{2'b10, 16, 1'b0, 0});
      vecs.push_back('{2'b11, 25, 1'b1, 0});

      mode = 2'b00;
      data_in = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("reset data_out", dout_a, 0);
      check("reset bit_valid", bv_a, 0);
      check("reset bit_value", bval_a, 0);
      check("reset armed", arm_a, 0);
      check("reset overrun", ovr_a, 0);
      @(negedge clk);
      reset = 1'b1;

      // idle line never arms
      flag_arm = 0; flag_bv = 0; flag_dout = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (arm_a) flag_arm = 1;
         if (bv_a) flag_bv = 1;
         if (dout_a) flag_dout = 1;
      end
      check("idle armed seen", flag_arm, 0);
      check("idle bit_valid seen", flag_bv, 0);
      check("idle data_out seen", flag_dout, 0);

      // table: single window of leading ones, then zeros
      foreach (vecs[vi]) begin
         do_reset();
         mode = vecs[vi].md;
         bv_seen = 0;
         for (int i = 0; i < WINDOW; i++) begin
            @(negedge clk);
            if (bv_a) bv_seen++;
            data_in = (i < vecs[vi].ones);
         end
         @(negedge clk);
         data_in = 1'b0;
         check($sformatf("vec%0d early valid", vi), bv_seen, 0);
         check($sformatf("vec%0d bit_valid", vi), bv_a, 1);
         check($sformatf("vec%0d bit_value", vi), bval_a, vecs[vi].exp_bit);
         check($sformatf("vec%0d data_out at valid", vi), dout_a, 0);
         cnt = 0; first = -1; bv_obs = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bv_a) bv_obs++;
            if (dout_a) begin
               cnt++;
               if (first < 0) first = k;
            end
         end
         check($sformatf("vec%0d high cycles", vi), cnt, vecs[vi].exp_len);
         if (vecs[vi].exp_len > 0) check($sformatf("vec%0d pulse start", vi), first, 0);
         check($sformatf("vec%0d next window valid", vi), bv_obs, 1);
      end

      // two back-to-back 1-windows: HOLDOFF=32 pulses twice, HOLDOFF=48 drops one
      do_reset();
      mode = 2'b00;
      na = 0; nb = 0;
      for (int j = 0; j < 120; j++) begin
         @(negedge clk);
         na += int'(dout_a);
         nb += int'(dout_b);
         data_in = (j < 64);
      end
      check("holdoff32 high cycles", na, 64);
      check("holdoff48 high cycles", nb, 32);
      check("holdoff32 overrun", ovr_a, 0);
      check("holdoff48 overrun", ovr_b, 1);
      drop = 0;
      for (int j = 0; j < 150; j++) begin
         @(negedge clk);
         if (!ovr_b) drop = 1;
         data_in = $urandom_range(1);
         mode = 2'($urandom_range(3));
      end
      check("overrun sticky", drop, 0);
      do_reset();
      check("overrun cleared by reset", ovr_b, 0);

      // idle disarm after eight 0-windows
      mode = 2'b00;
      nbv = 0;
      cyc = 0;
      while (nbv < 9 && cyc < 400) begin
         @(negedge clk);
         if (bv_a) begin
            nbv++;
            if (nbv == 8) check("idle still armed at 7th zero window", arm_a, 1);
            if (nbv == 9) begin
               check("idle disarm armed", arm_a, 0);
               check("idle disarm bit_value", bval_a, 0);
            end
         end
         data_in = (cyc < WINDOW);
         cyc++;
      end
      check("idle window count", nbv, 9);
      data_in = 1'b0;
      bv_seen = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (bv_a) bv_seen++;
      end
      check("disarmed no valid", bv_seen, 0);
      check("disarmed armed", arm_a, 0);
      data_in = 1'b1;
      @(negedge clk);
      data_in = 1'b0;
      check("rearm on single one", arm_a, 1);

      // reset in the middle of a pulse
      do_reset();
      mode = 2'b00;
      first = -1;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (dout_a && first < 0) first = j;
         if (first >= 0 && j == first + 40) break;
         data_in = (j < 64);
      end
      check("midrst pulse start", first, 33);
      check("midrst pulse running", dout_a, 1);
      check("midrst overrun before", ovr_b, 1);
      #2 reset = 1'b0;
      #1;
      check("midrst data_out", dout_a, 0);
      check("midrst armed", arm_a, 0);
      check("midrst bit_value", bval_a, 0);
      check("midrst bit_valid", bv_a, 0);
      check("midrst overrun", ovr_b, 0);
      @(negedge clk);
      reset = 1'b1;

      // level mode, alternating windows, then random segments
      run_seg(8 * WINDOW + 10, 1'b1, "level");
      for (int s = 0; s < 12; s++) run_seg(600, 1'b0, $sformatf("rand%0d", s));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
